// File: rtl/hs_arbiter.sv
// hs_arbiter: round-robin arbiter sharing one 4-phase req/ack receiver link
// among N senders. The winner keeps the grant for one full handshake
// (FWD -> ACKD -> REL). An optional watchdog abandons a grant when the
// receiver never acknowledges. The winner's data is captured at grant time,
// so rx_data does not depend combinationally on the sender inputs.

`ifndef WIDTH
`define WIDTH 8
`endif

module hs_arbiter #(
    parameter int N  = 4,
    parameter int DW = `WIDTH,
    parameter int TO = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N-1:0]            src_req,
    input  logic [N*DW-1:0]         src_data,
    output logic [N-1:0]            src_ack,
    output logic                    rx_req,
    output logic [DW-1:0]           rx_data,
    input  logic                    rx_ack,
    output logic                    rx_en,
    output logic [$clog2(N)-1:0]    grant_id,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int IW = $clog2(N);
    // Watchdog counter must hold values up to TO-1; keep at least one bit.
    localparam int WW = (TO < 2) ? 1 : $clog2(TO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ACKD = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   grant_id_r, grant_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [WW-1:0]   wdog_r, wdog_s;
    logic [DW-1:0]   data_r, data_s;
    logic            done_r, done_s;
    logic            err_r, err_s;
    logic [IW-1:0]   pick_s;
    logic            timeout_s;

    // First requester at or after ptr, searched cyclically.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Index after id, wrapping N-1 back to 0 (N need not be a power of two).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] id);
        if (int'(id) == N - 1) begin
            return '0;
        end else begin
            return id + IW'(1);
        end
    endfunction

    // Round-robin selection and watchdog expiry decode.
    always_comb begin
        pick_s = rr_pick(src_req, ptr_r);
        if (TO != 0) begin
            timeout_s = (wdog_r == WW'(TO - 1));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state logic: handshake sequencing, pointer rotation, watchdog.
    always_comb begin
        state_s = state_r;
        grant_s = grant_id_r;
        ptr_s   = ptr_r;
        wdog_s  = wdog_r;
        data_s  = data_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                wdog_s = '0;
                if (en && (|src_req)) begin
                    grant_s = pick_s;
                    data_s  = src_data[pick_s*DW +: DW];
                    state_s = FWD;
                end else begin
                    state_s = IDLE;
                end
            end
            FWD: begin
                if (rx_ack) begin
                    state_s = ACKD;
                end else if (timeout_s) begin
                    // Abandon the grant; the sender stays unacked and may win later.
                    err_s   = 1'b1;
                    ptr_s   = next_idx(grant_id_r);
                    wdog_s  = '0;
                    state_s = IDLE;
                end else if (TO != 0) begin
                    wdog_s  = wdog_r + WW'(1);
                end else begin
                    wdog_s  = wdog_r;
                end
            end
            ACKD: begin
                if (!src_req[grant_id_r]) begin
                    state_s = REL;
                end else begin
                    state_s = ACKD;
                end
            end
            REL: begin
                if (!rx_ack) begin
                    done_s  = 1'b1;
                    ptr_s   = next_idx(grant_id_r);
                    wdog_s  = '0;
                    state_s = IDLE;
                end else begin
                    state_s = REL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            ptr_r      <= '0;
            wdog_r     <= '0;
            data_r     <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            grant_id_r <= grant_s;
            ptr_r      <= ptr_s;
            wdog_r     <= wdog_s;
            data_r     <= data_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        src_ack = '0;
        rx_req  = 1'b0;
        rx_data = '0;
        case (state_r)
            IDLE: begin
                rx_req  = 1'b0;
            end
            FWD: begin
                rx_req  = 1'b1;
                rx_data = data_r;
            end
            ACKD: begin
                rx_req              = 1'b1;
                rx_data             = data_r;
                src_ack[grant_id_r] = 1'b1;
            end
            REL: begin
                src_ack[grant_id_r] = 1'b1;
            end
            default: begin
                rx_req  = 1'b0;
            end
        endcase
    end

    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign err      = err_r;
    assign grant_id = grant_id_r;
    assign rx_en    = en;

endmodule

// File: tb/tb_hs_arbiter.sv
// Bench for hs_arbiter: reactive 4-phase senders and a 1-cycle registered
// receiver; expected handshake completions are queued as stimulus is issued
// and a negedge monitor pops and compares them on every done/err pulse.

module tb_hs_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en  = 1'b0;
    logic [N-1:0]    src_req = '0;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ack;
    logic            rx_req;
    logic [DW-1:0]   rx_data;
    logic            rx_ack = 1'b0;
    logic            rx_en;
    logic [1:0]      grant_id;
    logic            busy, done, err;

    always #5 clk = ~clk;

    hs_arbiter #(.N(N), .DW(DW), .TO(TO)) dut (
        .clk(clk), .rst(rst), .en(en),
        .src_req(src_req), .src_data(src_data), .src_ack(src_ack),
        .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack), .rx_en(rx_en),
        .grant_id(grant_id), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            is_err;
        int            id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] sdata [N] = '{8'h3C, 8'h5A, 8'hA5, 8'hC3};
    int            target [N] = '{0, 0, 0, 0};
    int            issued [N] = '{0, 0, 0, 0};
    logic          rcv_block = 1'b0;
    logic          rr_q = 1'b0;
    logic [N-1:0]  ack_q = '0;
    logic          gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit e, input int id);
        exp_t t;
        t.is_err = e;
        t.id     = id;
        t.data   = sdata[id];
        exp_q.push_back(t);
    endtask

    task automatic drain(input int max);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < max) begin
            @(negedge clk);
            c++;
        end
        if (c >= max) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial src_data = {sdata[3], sdata[2], sdata[1], sdata[0]};

    // Sample DUT outputs mid-cycle for the reactive agents.
    initial forever begin
        @(negedge clk);
        rr_q  = rx_req;
        ack_q = src_ack;
    end

    // Agents: registered receiver plus 4-phase senders, updated after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            src_req = '0;
            rx_ack  = 1'b0;
        end else begin
            rx_ack = rr_q && !rcv_block;
            for (int i = 0; i < N; i++) begin
                if (!src_req[i] && !ack_q[i] && issued[i] < target[i]) begin
                    src_req[i] = 1'b1;
                    issued[i]++;
                end else if (src_req[i] && ack_q[i]) begin
                    src_req[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pops on done/err, plus per-cycle output invariants.
    logic [DW-1:0] last_data = '0;
    logic          prev_busy = 1'b0;
    logic          seen_fall = 1'b0;
    int            low_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rx_req) last_data = rx_data;
        else chk("rx_data_idle", {24'd0, rx_data}, 32'd0);
        if (src_ack != 4'd0) chk("ack_winner", {28'd0, src_ack}, {28'd0, 4'd1 << grant_id});
        if (rst && (done || err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {31'd0, err}, {31'd0, e.is_err});
                chk("winner", {30'd0, grant_id}, e.id);
                chk("data", {24'd0, last_data}, {24'd0, e.data});
            end
        end
        if (gap_chk) begin
            if (busy && !prev_busy && seen_fall) chk("busy_gap", low_cnt, 32'd1);
            if (!busy && prev_busy) begin
                seen_fall = 1'b1;
                low_cnt   = 0;
            end
            if (!busy) low_cnt++;
        end else begin
            seen_fall = 1'b0;
            low_cnt   = 0;
        end
        prev_busy = busy;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int c;
        int fwd;
        int nb;
        bit saw_ack;

        // Reset state
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rx_req", {31'd0, rx_req}, 32'd0);
        chk("rst_src_ack", {28'd0, src_ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_rx_en", {31'd0, rx_en}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single sender 2, cycle-accurate timing
        push(1'b0, 2);
        target[2]++;
        c = 0;
        while (!src_req[2] && c < 10) begin @(negedge clk); c++; end
        chk("t_req_seen", {31'd0, src_req[2]}, 32'd1);
        @(negedge clk);
        chk("t1_rx_req", {31'd0, rx_req}, 32'd1);
        chk("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        chk("t1_src_ack", {28'd0, src_ack}, 32'd0);
        @(negedge clk);
        chk("t2_src_ack", {28'd0, src_ack}, 32'd0);
        @(negedge clk);
        chk("t3_src_ack", {28'd0, src_ack}, 32'h4);
        repeat (4) @(negedge clk);
        chk("t7_done", {31'd0, done}, 32'd1);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_grant_id", {30'd0, grant_id}, 32'd2);
        drain(50);

        // Wrap: pointer at 3, requests on 1 and 3
        push(1'b0, 3);
        push(1'b0, 1);
        target[1]++;
        target[3]++;
        drain(100);

        // All four continuously from reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gap_chk = 1'b1;
        push(1'b0, 0); push(1'b0, 1); push(1'b0, 2); push(1'b0, 3); push(1'b0, 0);
        target[0] += 2;
        target[1]++;
        target[2]++;
        target[3]++;
        drain(300);
        gap_chk = 1'b0;

        // Watchdog: receiver never acks; pointer at 1, requests on 1 and 2
        rcv_block = 1'b1;
        push(1'b1, 1);
        push(1'b0, 2);
        push(1'b0, 1);
        target[1]++;
        target[2]++;
        c = 0;
        while (!rx_req && c < 10) begin @(negedge clk); c++; end
        fwd = 0;
        saw_ack = 1'b0;
        while (!err && fwd < 40) begin
            if (rx_req) fwd++;
            if (src_ack != 4'd0) saw_ack = 1'b1;
            @(negedge clk);
        end
        chk("wdog_cycles", fwd, 32'd16);
        chk("wdog_no_ack", {31'd0, saw_ack}, 32'd0);
        chk("wdog_err", {31'd0, err}, 32'd1);
        rcv_block = 1'b0;
        @(negedge clk);
        chk("wdog_err_pulse", {31'd0, err}, 32'd0);
        drain(200);

        // en dropped during ACKD; pointer at 2
        push(1'b0, 3);
        target[3]++;
        c = 0;
        while (!src_ack[3] && c < 20) begin @(negedge clk); c++; end
        chk("en_ackd_reached", {31'd0, src_ack[3]}, 32'd1);
        en = 1'b0;
        push(1'b0, 0);
        target[0]++;
        @(negedge clk);
        chk("en0_rx_en", {31'd0, rx_en}, 32'd0);
        c = 0;
        while (busy && c < 20) begin @(negedge clk); c++; end
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("en0_no_grant", nb, 32'd0);
        chk("en0_req_pending", {31'd0, src_req[0]}, 32'd1);
        en = 1'b1;
        drain(100);

        // Reset asserted during ACKD; pointer at 1
        target[2]++;
        c = 0;
        while (!src_ack[2] && c < 20) begin @(negedge clk); c++; end
        chk("rst_ackd_reached", {31'd0, src_ack[2]}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rx_req", {31'd0, rx_req}, 32'd0);
        chk("mrst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("mrst_src_ack", {28'd0, src_ack}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("mrst_rx_en", {31'd0, rx_en}, 32'd1);
        push(1'b0, 0);
        push(1'b0, 2);
        target[0]++;
        target[2]++;
        rst = 1'b1;
        drain(200);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_arbiter.md
# hs_arbiter

Round-robin arbiter that shares one 4-phase req/ack receiver link among `N` senders. Each sender runs a full 4-phase handshake against the arbiter. The arbiter forwards the winning sender's request and data to the downstream receiver and routes the receiver's acknowledge back. A grant is held for one complete 4-phase cycle, and an optional watchdog recovers from a receiver that never acknowledges.

## Interface
Parameters:
- `N`, 4: number of senders (2..8).
- `DW`, `` `WIDTH `` (from defines.sv): data width.
- `TO`, 16: watchdog limit in cycles for waiting on `rx_ack`. A value of 0 disables the watchdog.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-low.
- `en`  in  1: arbitration enable; also drives `rx_en`.
- `src_req`  in  N: per-sender request.
- `src_data`  in  N*DW: sender i data in bits [i*DW +: DW].
- `src_ack`  out  N: per-sender acknowledge; one-hot or zero.
- `rx_req`  out  1: request to the receiver.
- `rx_data`  out  DW: data to the receiver.
- `rx_ack`  in  1: acknowledge from the receiver.
- `rx_en`  out  1: receiver enable, equal to `en`.
- `grant_id`  out  $clog2(N): index of the current or last winner.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse when a handshake completes.
- `err`  out  1: one-cycle pulse on watchdog timeout.

## Operation
- **Reset:** state=IDLE, rr pointer=0, `grant_id`=0, watchdog=0. All outputs are 0 except `rx_en`, which follows `en`.
- **IDLE:** `rx_req`=0, `src_ack`=0, `rx_data`=0. If `en`=1 and any `src_req` is high, pick the first requester at or after the rr pointer (cyclic). Register it into `grant_id` and go to FWD.
- **FWD:**
  - `rx_req`=1, `rx_data`=`src_data[grant_id]`, `src_ack`=0.
  - The watchdog increments every cycle.
  - `rx_ack`=1 → go to ACKD.
  - Watchdog reaches `TO` (when `TO`≠0) → pulse `err`, set rr pointer=`grant_id`+1, go to IDLE. The sender is never acked and may win again later.
- **ACKD:** `rx_req`=1, `rx_data`=winner data, `src_ack[grant_id]`=1. `src_req[grant_id]`=0 → go to REL.
- **REL:** `rx_req`=0, `rx_data`=0, `src_ack[grant_id]`=1. `rx_ack`=0 → pulse `done`, set rr pointer=`grant_id`+1 mod N, clear the watchdog, go to IDLE.
- **Outputs:** state-decoded combinationally from the registered state and `grant_id`; no input-to-output combinational paths. `src_ack` of non-winners is always 0.
- **Rotation:** the rr pointer advances only on `done` or `err`. When the pointer passes N-1 it wraps to 0.
- **`en`=0 mid-transaction:** the current handshake runs to completion; no new grant is issued while `en`=0.
- **Winner drops `src_req` in FWD** (protocol violation): ignored. The arbiter stays in FWD until `rx_ack` or timeout. In ACKD, a low `src_req` already moves the arbiter to REL.
- **Simultaneous requests:** a single grant goes to the pointer-nearest requester. The other requests stay pending with no ack.
- **Reset mid-transaction:** the arbiter returns to IDLE the next edge and all handshake outputs drop. The receiver is expected to be reset by the same `rst`.

## Timing
- Grant latency: a request sampled high at edge t (arbiter in IDLE) gives `rx_req`=1 from t+1.
- With the 1-cycle registered receiver:
  - `rx_ack` rises at t+2.
  - ACKD begins and `src_ack` rises at t+3.
- If the source drops `src_req` at t+4 (sampled high in ACKD at t+3, low at the t+4 edge):
  - REL begins at t+5 and `rx_req` falls.
  - `rx_ack` falls at t+6.
  - `done` pulses and the arbiter is in IDLE at t+7, with `src_ack`=0.
- The next grant is possible from that same IDLE cycle (one cycle gap minimum).
- Watchdog: `err` fires after `TO` consecutive FWD cycles with no `rx_ack`.

## Test plan
- **Single sender:** N=4, only `src_req[2]`=1, `src_data[2]`=0xA5. Expect `rx_req` at t+1, `rx_data`=0xA5 while `rx_req`=1, `src_ack[2]` at t+3. After the sender drops its req: `done` pulses, `grant_id`=2, next pointer=3.
- **All four requesting continuously from reset:** grants go 0,1,2,3,0 with exactly one `done` each. No `src_ack` overlap; `busy` is low for exactly 1 cycle between grants.
- **Wrap:** pointer=3 with requests on 1 and 3 → grant 3, then 1.
- **Watchdog:** receiver `en` forced low (`rx_ack` stuck at 0), `TO`=16 → `err` at the 16th FWD cycle, `src_ack` never asserted, pointer advanced, next requester served.
- **`en` dropped:** `en` goes low in ACKD → transaction completes with `done`; no new grant until `en`=1 again.
- **Reset:** `rst`=0 asserted in ACKD → next cycle all outputs 0, state IDLE, `grant_id`=0; the first grant after release goes to sender 0.
